// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: architectural HI/LO plus a countdown that models mult/div latency.
// Define MDU_MADD_EN to accept madd/maddu (md_op 9/10) as accumulate-into-{HI,LO} ops.
module e_mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  md_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] md_out,
    output logic [31:0] hi_q,
    output logic [31:0] lo_q
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_CYCLES);

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MFHI  = 4'd5,
        OP_MFLO  = 4'd6,
        OP_MTHI  = 4'd7,
        OP_MTLO  = 4'd8,
        OP_MADD  = 4'd9,
        OP_MADDU = 4'd10
    } md_op_e;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic [31:0]      hi_d, lo_d;
    logic [31:0]      pend_hi_q, pend_hi_d;
    logic [31:0]      pend_lo_q, pend_lo_d;
    logic             pend_valid_q, pend_valid_d;

    logic [63:0] prod_s, prod_u;
    logic [31:0] quo_s, rem_s, quo_u, rem_u;

    assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    assign prod_u = {32'b0, A} * {32'b0, B};

`ifdef MDU_MADD_EN
    logic [63:0] acc_s, acc_u;
    // Accumulate base is the committed HI/LO as seen at the start edge.
    assign acc_s = {hi_q, lo_q} + prod_s;
    assign acc_u = {hi_q, lo_q} + prod_u;
`endif

    // The one signed-overflow quotient is pinned explicitly rather than left to the divider.
    always_comb begin
        quo_s = '0;
        rem_s = '0;
        quo_u = '0;
        rem_u = '0;
        if (B != 32'd0) begin
            if (A == 32'h8000_0000 && B == 32'hFFFF_FFFF) begin
                quo_s = 32'h8000_0000;
                rem_s = 32'd0;
            end else begin
                quo_s = $signed(A) / $signed(B);
                rem_s = $signed(A) % $signed(B);
            end
            quo_u = A / B;
            rem_u = A % B;
        end
    end

    always_comb begin
        // NOTE: every variable gets its hold value first so no path can infer a latch.
        cnt_d        = cnt_q;
        hi_d         = hi_q;
        lo_d         = lo_q;
        pend_hi_d    = pend_hi_q;
        pend_lo_d    = pend_lo_q;
        pend_valid_d = pend_valid_q;

        if (cnt_q == CNT_W'(1)) begin
            cnt_d        = '0;
            pend_valid_d = 1'b0;
            if (pend_valid_q) begin
                hi_d = pend_hi_q;
                lo_d = pend_lo_q;
            end
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end else if (start) begin
            case (md_op)
                OP_MULT: begin
                    {pend_hi_d, pend_lo_d} = prod_s;
                    pend_valid_d           = 1'b1;
                    cnt_d                  = MULT_CNT;
                end
                OP_MULTU: begin
                    {pend_hi_d, pend_lo_d} = prod_u;
                    pend_valid_d           = 1'b1;
                    cnt_d                  = MULT_CNT;
                end
                OP_DIV: begin
                    pend_hi_d    = rem_s;
                    pend_lo_d    = quo_s;
                    pend_valid_d = (B != 32'd0);
                    cnt_d        = DIV_CNT;
                end
                OP_DIVU: begin
                    pend_hi_d    = rem_u;
                    pend_lo_d    = quo_u;
                    pend_valid_d = (B != 32'd0);
                    cnt_d        = DIV_CNT;
                end
                OP_MTHI: hi_d = A;
                OP_MTLO: lo_d = A;
`ifdef MDU_MADD_EN
                OP_MADD: begin
                    {pend_hi_d, pend_lo_d} = acc_s;
                    pend_valid_d           = 1'b1;
                    cnt_d                  = MULT_CNT;
                end
                OP_MADDU: begin
                    {pend_hi_d, pend_lo_d} = acc_u;
                    pend_valid_d           = 1'b1;
                    cnt_d                  = MULT_CNT;
                end
`endif
                default: ;
            endcase
        end

        busy_d = (cnt_d != '0);
    end

    // NOTE: the pending-result registers are reset too, so a reset mid-operation can never leak a stale commit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q        <= '0;
            busy_q       <= 1'b0;
            hi_q         <= '0;
            lo_q         <= '0;
            pend_hi_q    <= '0;
            pend_lo_q    <= '0;
            pend_valid_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values of its peers.
            cnt_q        <= cnt_d;
            busy_q       <= busy_d;
            hi_q         <= hi_d;
            lo_q         <= lo_d;
            pend_hi_q    <= pend_hi_d;
            pend_lo_q    <= pend_lo_d;
            pend_valid_q <= pend_valid_d;
        end
    end

    assign busy = busy_q;

    always_comb begin
        md_out = '0;
        if (md_op == OP_MFHI)      md_out = hi_q;
        else if (md_op == OP_MFLO) md_out = lo_q;
    end

endmodule

// File: tb/tb_e_mdu.sv
// Randomized and directed bench for e_mdu against an arithmetic reference model of HI/LO and busy.
module tb_e_mdu;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  md_op;
    logic [31:0] A, B;
    logic        busy;
    logic [31:0] md_out, hi_q, lo_q;

    e_mdu #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .md_op  (md_op),
        .A      (A),
        .B      (B),
        .busy   (busy),
        .md_out (md_out),
        .hi_q   (hi_q),
        .lo_q   (lo_q)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: committed HI/LO, one outstanding result, and the edge index at which it lands.
    logic [31:0] m_hi = '0, m_lo = '0;
    logic [63:0] pend_val = '0;
    bit          pend = 1'b0;
    int          edges = 0;
    int          done_edge = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, edges);
        end
    endtask

    function automatic logic [63:0] mul_s(input logic [31:0] a, input logic [31:0] b);
        int     sa = a;
        int     sb = b;
        longint la = sa;
        longint lb = sb;
        return la * lb;
    endfunction

    function automatic logic [63:0] mul_u(input logic [31:0] a, input logic [31:0] b);
        longint unsigned ua = a;
        longint unsigned ub = b;
        return ua * ub;
    endfunction

    task automatic model_reset();
        m_hi      = '0;
        m_lo      = '0;
        pend      = 1'b0;
        done_edge = edges;
    endtask

    task automatic model_edge(input bit s, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int     sa = a;
        int     sb = b;
        longint q, r;
        edges++;
        if (edges == done_edge) begin
            if (pend) {m_hi, m_lo} = pend_val;
            pend = 1'b0;
        end else if (edges > done_edge && s) begin
            case (op)
                4'd1: begin pend_val = mul_s(a, b); pend = 1'b1; done_edge = edges + MULT_N; end
                4'd2: begin pend_val = mul_u(a, b); pend = 1'b1; done_edge = edges + MULT_N; end
                4'd3: begin
                    pend = (b != 0);
                    if (pend) begin
                        q = longint'(sa) / longint'(sb);
                        r = longint'(sa) - q * longint'(sb);
                        pend_val = {r[31:0], q[31:0]};
                    end
                    done_edge = edges + DIV_N;
                end
                4'd4: begin
                    pend = (b != 0);
                    if (pend) pend_val = {b == 0 ? 32'd0 : a % b, b == 0 ? 32'd0 : a / b};
                    done_edge = edges + DIV_N;
                end
                4'd7: m_hi = a;
                4'd8: m_lo = a;
`ifdef MDU_MADD_EN
                4'd9:  begin pend_val = {m_hi, m_lo} + mul_s(a, b); pend = 1'b1; done_edge = edges + MULT_N; end
                4'd10: begin pend_val = {m_hi, m_lo} + mul_u(a, b); pend = 1'b1; done_edge = edges + MULT_N; end
`endif
                default: ;
            endcase
        end
    endtask

    // One clock: drive, check combinational read, clock, check registered state.
    task automatic do_cycle(input bit s, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        start = s;
        md_op = op;
        A     = a;
        B     = b;
        #1;
        check("md_out", md_out, op == 4'd5 ? m_hi : (op == 4'd6 ? m_lo : 32'd0));
        @(posedge clk);
        model_edge(s, op, a, b);
        #1;
        check("busy", {31'b0, busy}, {31'b0, edges < done_edge});
        check("hi", hi_q, m_hi);
        check("lo", lo_q, m_lo);
    endtask

    // Issue one op, then idle long enough for any latency; returns observed busy cycle count.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, output int nbusy);
        do_cycle(1'b1, op, a, b);
        nbusy = int'(busy);
        for (int i = 0; i < DIV_N + 2; i++) begin
            do_cycle(1'b0, 4'd0, 32'd0, 32'd0);
            nbusy += int'(busy);
        end
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int nb;
        reset = 1'b1;
        start = 1'b0;
        md_op = 4'd0;
        A     = '0;
        B     = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_hi", hi_q, 32'd0);
        check("rst_lo", lo_q, 32'd0);

        run_op(4'd1, 32'hFFFF_FFFF, 32'd2, nb);
        check("mult_len", nb, MULT_N);
        check("mult_hi", hi_q, 32'hFFFF_FFFF);
        check("mult_lo", lo_q, 32'hFFFF_FFFE);

        run_op(4'd2, 32'hFFFF_FFFF, 32'd2, nb);
        check("multu_len", nb, MULT_N);
        check("multu_hi", hi_q, 32'h0000_0001);
        check("multu_lo", lo_q, 32'hFFFF_FFFE);
        md_op = 4'd6;
        #1;
        check("mflo", md_out, 32'hFFFF_FFFE);

        run_op(4'd3, 32'hFFFF_FFF9, 32'd2, nb);
        check("div_len", nb, DIV_N);
        check("div_lo", lo_q, 32'hFFFF_FFFD);
        check("div_hi", hi_q, 32'hFFFF_FFFF);

        run_op(4'd4, 32'd7, 32'd0, nb);
        check("divu0_len", nb, DIV_N);
        check("divu0_hi", hi_q, 32'hFFFF_FFFF);
        check("divu0_lo", lo_q, 32'hFFFF_FFFD);

        run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, nb);
        check("divovf_lo", lo_q, 32'h8000_0000);
        check("divovf_hi", hi_q, 32'd0);

        // Starts issued while busy must be ignored.
        do_cycle(1'b1, 4'd3, 32'd100, 32'd7);
        nb = int'(busy);
        do_cycle(1'b1, 4'd1, 32'd5, 32'd6);
        nb += int'(busy);
        do_cycle(1'b1, 4'd7, 32'h1234, 32'd0);
        nb += int'(busy);
        for (int i = 0; i < DIV_N; i++) begin
            do_cycle(1'b0, 4'd0, 32'd0, 32'd0);
            nb += int'(busy);
        end
        check("ign_len", nb, DIV_N);
        check("ign_lo", lo_q, 32'd14);
        check("ign_hi", hi_q, 32'd2);

        // Asynchronous reset in the middle of a divide.
        run_op(4'd7, 32'h55, 32'd0, nb);
        check("mthi_len", nb, 0);
        do_cycle(1'b1, 4'd3, 32'd100, 32'd3);
        do_cycle(1'b0, 4'd0, 32'd0, 32'd0);
        do_cycle(1'b0, 4'd0, 32'd0, 32'd0);
        #2;
        reset = 1'b1;
        #1;
        check("arst_busy", {31'b0, busy}, 32'd0);
        check("arst_hi", hi_q, 32'd0);
        check("arst_lo", lo_q, 32'd0);
        #1;
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < DIV_N + 3; i++) do_cycle(1'b0, 4'd0, 32'd0, 32'd0);
        check("post_rst_lo", lo_q, 32'd0);

        // Multiply-accumulate, or its absence in the default build.
        run_op(4'd8, 32'd1, 32'd0, nb);
        run_op(4'd7, 32'd0, 32'd0, nb);
        run_op(4'd9, 32'd3, 32'd4, nb);
`ifdef MDU_MADD_EN
        check("madd_len", nb, MULT_N);
        check("madd_lo", lo_q, 32'd13);
`else
        check("madd_len", nb, 0);
        check("madd_lo", lo_q, 32'd1);
`endif
        check("madd_hi", hi_q, 32'd0);

        for (int i = 0; i < 600; i++) begin
            logic [3:0] op;
            op = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 10));
            do_cycle($urandom_range(0, 2) != 0, op, pick_operand(), pick_operand());
        end
        for (int i = 0; i < DIV_N + 1; i++) do_cycle(1'b0, 4'd5, 32'd0, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
